mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter.sv | 145 ++++++++++++++
 tb/tb_mult_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin front end that shares one external multiplier among NREQ requesters.
// Optional build macro MULT_ARBITER_ZERO_BYPASS_EN: zero operands skip the multiplier.
module mult_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*W-1:0]         a_in,
  input  logic [NREQ*W-1:0]         b_in,
  output logic [NREQ-1:0]           gnt,
  output logic                      resp_valid,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic [2*W-1:0]            resp_product,
  output logic                      busy,
  output logic                      mul_start,
  output logic [W-1:0]              mul_a,
  output logic [W-1:0]              mul_b,
  input  logic [2*W-1:0]            mul_product,
  input  logic                      mul_done
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_RESP,
    S_COOL
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   last_q;
  logic [NREQ-1:0]  gnt_q;
  logic             resp_valid_q;
  logic [IDW-1:0]   resp_id_q;
  logic [2*W-1:0]   resp_product_q;
  logic             busy_q;
  logic             mul_start_q;
  logic [W-1:0]     mul_a_q;
  logic [W-1:0]     mul_b_q;

  logic [IDW-1:0]   win_idx;
  logic             win_vld;
  logic [IDW-1:0]   cand;
  logic [W-1:0]     a_sel;
  logic [W-1:0]     b_sel;
  logic             zero_sel;
  logic             zero_cap;

  // Search starts one past the last granted requester and wraps.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDW'((32'(last_q) + i) % NREQ);
      if (!win_vld && req[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
  end

  assign a_sel = a_in[win_idx*W +: W];
  assign b_sel = b_in[win_idx*W +: W];

`ifdef MULT_ARBITER_ZERO_BYPASS_EN
  assign zero_sel = (a_sel == '0) || (b_sel == '0);
  assign zero_cap = (mul_a_q == '0) || (mul_b_q == '0);
`else
  assign zero_sel = 1'b0;
  assign zero_cap = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      last_q         <= IDW'(NREQ - 1);
      gnt_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_product_q <= '0;
      busy_q         <= 1'b0;
      mul_start_q    <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
    end else begin
      gnt_q        <= '0;
      resp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            mul_a_q     <= a_sel;
            mul_b_q     <= b_sel;
            resp_id_q   <= win_idx;
            last_q      <= win_idx;
            gnt_q       <= NREQ'(1) << win_idx;
            mul_start_q <= !zero_sel;
            busy_q      <= 1'b1;
            state_q     <= S_LAUNCH;
          end
        end
        // Bypassed operations only ever sit in LAUNCH, so zero_cap never matters in RUN.
        S_LAUNCH, S_RUN: begin
          if (zero_cap) begin
            resp_product_q <= '0;
            resp_valid_q   <= 1'b1;
            mul_start_q    <= 1'b0;
            state_q        <= S_RESP;
          end else if (mul_done) begin
            resp_product_q <= mul_product;
            resp_valid_q   <= 1'b1;
            mul_start_q    <= 1'b0;
            state_q        <= S_RESP;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_RESP: begin
          state_q <= S_COOL;
        end
        S_COOL: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt          = gnt_q;
  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_product = resp_product_q;
  assign busy         = busy_q;
  assign mul_start    = mul_start_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed plus randomized bench for mult_arbiter with a transaction-level reference
// model (round-robin pick, operand product) and an emulated shared multiplier.
module tb_mult_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int IDW  = 2;
  localparam int PW   = 2 * W;
`ifdef MULT_ARBITER_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] a_in;
  logic [NREQ*W-1:0] b_in;
  logic [NREQ-1:0]   gnt;
  logic              resp_valid;
  logic [IDW-1:0]    resp_id;
  logic [PW-1:0]     resp_product;
  logic              busy;
  logic              mul_start;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [PW-1:0]     mul_product;
  logic              mul_done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]    a_v [NREQ];
  logic [W-1:0]    b_v [NREQ];
  logic [NREQ-1:0] req_v;
  int              ptr;

  always #5 clk = ~clk;

  mult_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .a_in         (a_in),
    .b_in         (b_in),
    .gnt          (gnt),
    .resp_valid   (resp_valid),
    .resp_id      (resp_id),
    .resp_product (resp_product),
    .busy         (busy),
    .mul_start    (mul_start),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_product  (mul_product),
    .mul_done     (mul_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pack();
    for (int i = 0; i < NREQ; i++) begin
      a_in[i*W +: W] = a_v[i];
      b_in[i*W +: W] = b_v[i];
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (r[IDW'((last + k) % NREQ)]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  // One full operation starting from IDLE: grant, multiply, response, cool-down.
  task automatic transact(input int lat, input bit drop);
    int            exp_id;
    int            waited;
    logic [PW-1:0] exp_p;
    bit            byp;
    pack();
    req    = req_v;
    exp_id = rr_pick(req_v, ptr);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (gnt == '0 && waited < 20);
    chk("gnt_latency", 64'(waited), 64'd1);
    chk("gnt_onehot", gnt, 64'(1 << exp_id));
    chk("launch_id", resp_id, 64'(exp_id));
    chk("mul_a", mul_a, a_v[exp_id]);
    chk("mul_b", mul_b, b_v[exp_id]);
    byp   = BYP && (a_v[exp_id] == '0 || b_v[exp_id] == '0);
    exp_p = PW'(a_v[exp_id]) * PW'(b_v[exp_id]);
    chk("mul_start_launch", mul_start, !byp);
    chk("busy_launch", busy, 1);
    ptr = exp_id;
    if (drop) req_v[exp_id] = 1'b0;
    if (!byp) begin
      for (int d = 0; d < lat; d++) begin
        req = NREQ'($urandom);
        tick();
        chk("mul_start_run", mul_start, 1);
        chk("gnt_pulse", gnt, 0);
        chk("no_early_resp", resp_valid, 0);
      end
      mul_done    = 1'b1;
      mul_product = PW'(mul_a) * PW'(mul_b);
    end
    req = req_v;
    tick();
    mul_done    = 1'b0;
    mul_product = PW'($urandom);
    chk("resp_valid", resp_valid, 1);
    chk("resp_id", resp_id, 64'(exp_id));
    chk("resp_product", resp_product, exp_p);
    chk("mul_start_resp", mul_start, 0);
    chk("gnt_resp", gnt, 0);
    mul_done = 1'b1;
    tick();
    chk("resp_valid_cool", resp_valid, 0);
    chk("busy_cool", busy, 1);
    chk("mul_start_cool", mul_start, 0);
    tick();
    mul_done = 1'b0;
    chk("busy_idle", busy, 0);
    chk("resp_valid_idle", resp_valid, 0);
    chk("product_held", resp_product, exp_p);
  endtask

  initial begin
    rst         = 1'b1;
    req         = '0;
    a_in        = '0;
    b_in        = '0;
    mul_done    = 1'b0;
    mul_product = '0;
    ptr         = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    tick();
    tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_start", mul_start, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_product", resp_product, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    rst = 1'b0;

    // no request: stays idle
    repeat (3) begin
      tick();
      chk("idle_gnt", gnt, 0);
      chk("idle_busy", busy, 0);
    end

    // all four requesting, twice: order 0,1,2,3 each round
    for (int round = 0; round < 2; round++) begin
      req_v = 4'b1111;
      for (int i = 0; i < NREQ; i++) begin
        a_v[i] = rnd_op();
        b_v[i] = rnd_op();
      end
      for (int i = 0; i < NREQ; i++) transact(1 + i, 1'b1);
    end

    // single request 3*5, done 8 cycles after launch
    req_v  = 4'b0001;
    a_v[0] = 16'd3;
    b_v[0] = 16'd5;
    transact(8, 1'b1);

    // pointer wrap: grant 2, then 0101 -> 0, then 0101 -> 2
    req_v  = 4'b0100;
    a_v[2] = 16'd100;
    b_v[2] = 16'd7;
    transact(2, 1'b1);
    req_v  = 4'b0101;
    a_v[0] = 16'd11;
    b_v[0] = 16'd13;
    transact(0, 1'b1);
    transact(3, 1'b1);

    // maximum operands
    req_v  = 4'b1000;
    a_v[3] = 16'hFFFF;
    b_v[3] = 16'hFFFF;
    transact(4, 1'b1);
    chk("max_product", resp_product, 64'hFFFE0001);

    // zero operand
    req_v  = 4'b0010;
    a_v[1] = 16'd0;
    b_v[1] = 16'd1234;
    transact(3, 1'b1);
    chk("zero_product", resp_product, 0);

    // reset three cycles into an operation; the held request is re-granted afterwards
    req_v  = 4'b0100;
    a_v[2] = 16'd1234;
    b_v[2] = 16'd77;
    pack();
    req = req_v;
    tick();
    chk("abort_gnt", gnt, 4'b0100);
    repeat (3) begin
      tick();
      chk("abort_no_resp", resp_valid, 0);
      chk("abort_mul_start", mul_start, 1);
    end
    rst = 1'b1;
    #1;
    chk("abort_gnt_zero", gnt, 0);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_mul_start0", mul_start, 0);
    chk("abort_busy", busy, 0);
    chk("abort_resp_id", resp_id, 0);
    chk("abort_product", resp_product, 0);
    chk("abort_mul_a", mul_a, 0);
    chk("abort_mul_b", mul_b, 0);
    tick();
    rst = 1'b0;
    ptr = NREQ - 1;
    transact(2, 1'b1);

    // randomized traffic
    req_v = '0;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_v[i]) begin
          a_v[i] = rnd_op();
          b_v[i] = rnd_op();
        end
      end
      req_v = req_v | NREQ'($urandom_range(0, 15));
      if (req_v == '0) req_v = 4'b0001;
      transact(int'($urandom_range(0, 5)), bit'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
